cart_loader: RTL and testbench

- Sits between the hps_io ioctl download stream and the SDRAM write port.
- Accepts cartridge bytes, issues one toggle-handshake SDRAM write per byte, and throttles the stream with ioctl_wait.
- Detects a 512-byte copier header, derives the cartridge address mask and the GG flag.
- Translates system ROM read addresses into SDRAM addresses for the rest of the design.

---
 rtl/cart_loader.sv | 211 +++++++++++++++++++++
 tb/tb_cart_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_loader.sv
// cart_loader: moves ioctl download bytes into SDRAM through a toggle handshake.
// It also detects a 512-byte copier header and derives the cartridge mask and GG flag.
// It translates ROM read addresses into SDRAM read addresses.
// Optional feature: define CART_CHECKSUM_EN to add a 16-bit payload checksum output.
module cart_loader #(
    parameter int         AW        = 22,
    parameter int         HDR_BYTES = 512,
    parameter logic [4:0] GG_INDEX  = 5'd2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic          mem_ack,
    input  logic [AW-1:0] rom_a,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] cart_mask,
    output logic          hdr,
    output logic          gg,
    output logic          loaded,
`ifdef CART_CHECKSUM_EN
    output logic [15:0]   checksum,
`endif
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RECV, WRPEND, FINISH} state_t;

    localparam logic [24:0]   HDR_CNT = 25'(HDR_BYTES);
    localparam logic [AW-1:0] HDR_OFS = AW'(HDR_BYTES);

    state_t      state;
    state_t      state_next;
    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;
    logic        fall_pend;
    logic [24:0] byte_cnt;
    logic [24:0] addr_end;
    logic        start_load;
    logic        take_byte;
    logic        write_acked;
    logic        finish_load;
    logic        hdr_next;
    logic [24:0] payload;
    logic [24:0] span;
    logic [24:0] mask_full;
    logic        seen;
    logic        unused_idx;

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign addr_end   = ioctl_addr + 25'd1;
    assign unused_idx = ^ioctl_index[7:5];

    // State register, plus the previous download level used for edge detection
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            dl_q  <= 1'b0;
        end else begin
            state <= state_next;
            dl_q  <= ioctl_download;
        end
    end

    // Next-state decode and single-cycle control strobes for the datapath
    always_comb begin
        state_next  = state;
        start_load  = 1'b0;
        take_byte   = 1'b0;
        write_acked = 1'b0;
        finish_load = 1'b0;
        case (state)
            IDLE: begin
                if (dl_rise) begin
                    start_load = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (ioctl_wr) begin
                    take_byte  = 1'b1;
                    state_next = WRPEND;
                end else if (dl_fall) begin
                    state_next = FINISH;
                end
            end
            WRPEND: begin
                if (mem_we == mem_ack) begin
                    write_acked = 1'b1;
                    state_next  = (fall_pend || dl_fall) ? FINISH : RECV;
                end
            end
            FINISH: begin
                finish_load = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Header detection and mask rounding: smear the highest set bit of payload-1 downwards
    always_comb begin
        hdr_next  = (byte_cnt[8:0] == 9'd0) && byte_cnt[9] && (byte_cnt > HDR_CNT);
        payload   = byte_cnt - (hdr_next ? HDR_CNT : 25'd0);
        span      = payload - 25'd1;
        seen      = 1'b0;
        mask_full = '0;
        for (int i = 24; i >= 0; i--) begin
            seen         = seen | span[i];
            mask_full[i] = seen;
        end
        if (payload == 25'd0) begin
            mask_full = '0;
        end
    end

    // Download datapath: byte capture, write toggle, stall, byte count and load results
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ioctl_wait <= 1'b0;
            mem_waddr  <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            byte_cnt   <= '0;
            fall_pend  <= 1'b0;
            cart_mask  <= '0;
            hdr        <= 1'b0;
            gg         <= 1'b0;
            loaded     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_load) begin
                byte_cnt <= '0;
                loaded   <= 1'b0;
                gg       <= (ioctl_index[4:0] == GG_INDEX);
            end
            if (take_byte) begin
                mem_waddr  <= ioctl_addr[AW-1:0];
                mem_din    <= ioctl_dout;
                mem_we     <= ~mem_we;
                ioctl_wait <= 1'b1;
                if (addr_end > byte_cnt) begin
                    byte_cnt <= addr_end;
                end
            end
            if (write_acked) begin
                ioctl_wait <= 1'b0;
            end
            if (start_load || finish_load) begin
                fall_pend <= 1'b0;
            end else if (dl_fall && (take_byte || state == WRPEND)) begin
                fall_pend <= 1'b1;
            end
            if (finish_load) begin
                hdr       <= hdr_next;
                cart_mask <= AW'(mask_full);
                loaded    <= 1'b1;
                done      <= 1'b1;
            end
        end
    end

`ifdef CART_CHECKSUM_EN
    logic [15:0] sum_total;
    logic [15:0] sum_hdr;

    // Running byte sums; the header part is subtracted out once the header is confirmed
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_total <= '0;
            sum_hdr   <= '0;
            checksum  <= '0;
        end else begin
            if (start_load) begin
                sum_total <= '0;
                sum_hdr   <= '0;
                checksum  <= '0;
            end
            if (take_byte) begin
                sum_total <= sum_total + {8'd0, ioctl_dout};
                if (ioctl_addr < HDR_CNT) begin
                    sum_hdr <= sum_hdr + {8'd0, ioctl_dout};
                end
            end
            if (finish_load) begin
                checksum <= hdr_next ? (sum_total - sum_hdr) : sum_total;
            end
        end
    end
`endif

    // Registered ROM read translation, always using the last completed load's mask and header
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_raddr <= '0;
        end else begin
            mem_raddr <= (rom_a & cart_mask) + (hdr ? HDR_OFS : '0);
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: directed bench for cart_loader with an SDRAM responder and a write scoreboard.
module tb_cart_loader;

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        mem_ack = 1'b0;
    logic [21:0] rom_a = 22'd0;
    logic        ioctl_wait;
    logic [21:0] mem_waddr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [21:0] mem_raddr;
    logic [21:0] cart_mask;
    logic        hdr;
    logic        gg;
    logic        loaded;
    logic        done;
`ifdef CART_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int   checks = 0;
    int   failures = 0;
    int   ackDelay = 3;
    int   ackTimer = 0;
    int   toggles = 0;
    int   doneCount = 0;
    int   waitMin = 1000;
    int   waitMax = 0;
    int   earlyFinish = 0;
    exp_t sb[$];

    cart_loader dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .mem_waddr(mem_waddr),
        .mem_din(mem_din),
        .mem_we(mem_we),
        .mem_ack(mem_ack),
        .rom_a(rom_a),
        .mem_raddr(mem_raddr),
        .cart_mask(cart_mask),
        .hdr(hdr),
        .gg(gg),
        .loaded(loaded),
`ifdef CART_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // SDRAM responder: pops the scoreboard on each new toggle and acks after ackDelay cycles
    always @(negedge clk_sys) begin
        exp_t e;
        if (reset === 1'b1) begin
            mem_ack  = 1'b0;
            ackTimer = 0;
        end else if (mem_we !== mem_ack) begin
            if (ackTimer == 0) begin
                toggles++;
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("mem_waddr", 32'(mem_waddr), 32'(e.addr));
                    checkOutput("mem_din", 32'(mem_din), 32'(e.data));
                end
            end
            ackTimer++;
            if (ackTimer >= ackDelay) begin
                mem_ack  = mem_we;
                ackTimer = 0;
            end
        end
    end

    // Counts every cycle the done pulse is seen high
    always @(negedge clk_sys) begin
        if (done === 1'b1) begin
            doneCount++;
        end
    end

    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data, input bit dropDl);
        int w;
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = data;
        sb.push_back('{addr: addr[21:0], data: data});
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (dropDl) begin
            ioctl_download = 1'b0;
        end
        w = 0;
        while (ioctl_wait === 1'b1 && w < 100) begin
            if (loaded === 1'b1 || done === 1'b1) begin
                earlyFinish++;
            end
            @(negedge clk_sys);
            w++;
        end
        if (w >= 100) begin
            checkOutput("wait_timeout", 32'(w), 32'd0);
        end
        if (w < waitMin) waitMin = w;
        if (w > waitMax) waitMax = w;
    endtask

    task automatic startLoad(input logic [7:0] index);
        ioctl_index    = index;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        checkOutput("loaded_cleared", 32'(loaded), 32'd0);
    endtask

    task automatic loadSparse(input int nDense, input logic [24:0] lastAddr, input bit dropLast);
        for (int i = 0; i < nDense; i++) begin
            applyStimulus(25'(i), 8'((i * 7 + 3) & 8'hFF), 1'b0);
        end
        applyStimulus(lastAddr, 8'hA5, dropLast);
    endtask

    task automatic waitDone(input int startDone);
        int n;
        n = 0;
        while (loaded !== 1'b1 && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput("load_complete", 32'(loaded), 32'd1);
        checkOutput("done_with_loaded", 32'(done), 32'd1);
        repeat (3) @(negedge clk_sys);
        checkOutput("done_pulses", 32'(doneCount - startDone), 32'd1);
    endtask

    task automatic endLoad(input int startDone);
        ioctl_download = 1'b0;
        waitDone(startDone);
    endtask

    task automatic checkRead(input logic [21:0] addr, input logic [21:0] maskExp, input bit hdrExp, input string tag);
        logic [21:0] expRaddr;
        rom_a = addr;
        expRaddr = (addr & maskExp) + (hdrExp ? 22'd512 : 22'd0);
        @(negedge clk_sys);
        checkOutput(tag, 32'(mem_raddr), 32'(expRaddr));
    endtask

`ifdef CART_CHECKSUM_EN
    task automatic checksumLoad(input int nBytes, input bit hdrExp);
        logic [15:0] tot;
        logic [15:0] hsum;
        logic [7:0]  b;
        int          startDone;
        tot = '0;
        hsum = '0;
        startDone = doneCount;
        startLoad(8'd1);
        for (int i = 0; i < nBytes; i++) begin
            b = (i < 512) ? 8'hFF : 8'h01;
            tot = tot + {8'd0, b};
            if (i < 512) hsum = hsum + {8'd0, b};
            applyStimulus(25'(i), b, 1'b0);
        end
        endLoad(startDone);
        checkOutput("cks_hdr", 32'(hdr), 32'(hdrExp));
        checkOutput("checksum", 32'(checksum), 32'(hdrExp ? (tot - hsum) : tot));
    endtask
`endif

    initial begin
        int startDone;
        int startToggles;
        $display("[TB] cart_loader bench starting");
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        checkOutput("rst_wait", 32'(ioctl_wait), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_hdr", 32'(hdr), 32'd0);
        checkOutput("rst_gg", 32'(gg), 32'd0);
        checkOutput("rst_loaded", 32'(loaded), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_waddr", 32'(mem_waddr), 32'd0);
        checkOutput("rst_din", 32'(mem_din), 32'd0);
        checkOutput("rst_mask", 32'(cart_mask), 32'd0);
        checkOutput("rst_raddr", 32'(mem_raddr), 32'd0);

        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd77;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        checkOutput("idle_wr_ignored", 32'(toggles), 32'd0);

        $display("[TB] 16K SMS load, ack delay 3");
        ackDelay = 3;
        waitMin = 1000;
        waitMax = 0;
        startDone = doneCount;
        startToggles = toggles;
        startLoad(8'd1);
        loadSparse(32, 25'd16383, 1'b0);
        checkOutput("sms_toggles", 32'(toggles - startToggles), 32'd33);
        checkOutput("sms_wait_3to4", 32'(waitMin >= 3 && waitMax <= 4), 32'd1);
        endLoad(startDone);
        checkOutput("sms_mask", 32'(cart_mask), 32'h003FFF);
        checkOutput("sms_hdr", 32'(hdr), 32'd0);
        checkOutput("sms_gg", 32'(gg), 32'd0);

        $display("[TB] 100000-byte GG load");
        ackDelay = 1;
        startDone = doneCount;
        startLoad(8'd2);
        loadSparse(4, 25'd99999, 1'b0);
        endLoad(startDone);
        checkOutput("gg_flag", 32'(gg), 32'd1);
        checkOutput("gg_hdr", 32'(hdr), 32'd0);
        checkOutput("gg_mask", 32'(cart_mask), 32'h01FFFF);
        checkRead(22'h3ABCD, 22'h01FFFF, 1'b0, "gg_raddr");

        $display("[TB] download falls during the final pending write");
        ackDelay = 10;
        earlyFinish = 0;
        startDone = doneCount;
        startLoad(8'd1);
        loadSparse(4, 25'd2047, 1'b1);
        checkOutput("no_finish_before_ack", 32'(earlyFinish), 32'd0);
        waitDone(startDone);
        checkOutput("pend_mask", 32'(cart_mask), 32'h0007FF);
        checkOutput("pend_hdr", 32'(hdr), 32'd0);

        $display("[TB] 33280-byte load with copier header");
        ackDelay = 2;
        startDone = doneCount;
        startLoad(8'd1);
        checkRead(22'h07FFFF, 22'h0007FF, 1'b0, "raddr_prev_mask");
        loadSparse(8, 25'd33279, 1'b0);
        endLoad(startDone);
        checkOutput("hdr_flag", 32'(hdr), 32'd1);
        checkOutput("hdr_mask", 32'(cart_mask), 32'h007FFF);
        checkRead(22'h000000, 22'h007FFF, 1'b1, "raddr_0000");
        checkRead(22'h008005, 22'h007FFF, 1'b1, "raddr_8005");
        checkOutput("raddr_8005_const", 32'(mem_raddr), 32'h000205);

        $display("[TB] reset in the middle of a load");
        startLoad(8'd1);
        loadSparse(6, 25'h0400010, 1'b0);
        applyStimulus(25'd4999, 8'h3C, 1'b0);
        reset = 1'b1;
        @(negedge clk_sys);
        checkOutput("mid_rst_wait", 32'(ioctl_wait), 32'd0);
        checkOutput("mid_rst_loaded", 32'(loaded), 32'd0);
        checkOutput("mid_rst_mask", 32'(cart_mask), 32'd0);
        checkOutput("mid_rst_hdr", 32'(hdr), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        ioctl_download = 1'b0;
        sb.delete();
        @(negedge clk_sys);

        $display("[TB] 8192-byte load after reset");
        startDone = doneCount;
        startLoad(8'd1);
        loadSparse(4, 25'd8191, 1'b0);
        endLoad(startDone);
        checkOutput("post_rst_mask", 32'(cart_mask), 32'h001FFF);
        checkOutput("post_rst_hdr", 32'(hdr), 32'd0);

`ifdef CART_CHECKSUM_EN
        $display("[TB] checksum loads");
        ackDelay = 1;
        checksumLoad(1024, 1'b0);
        checkOutput("cks_1024_const", 32'(checksum), 32'h0000);
        checksumLoad(1536, 1'b1);
        checkOutput("cks_1536_const", 32'(checksum), 32'h0400);
`endif

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
